// File: rtl/d_card_driver.sv
// Card-side SD 4-bit D-line engine: streams RAM blocks to the host on send,
// captures host blocks into RAM on receive and answers with CRC status and busy.
module d_card_driver #(
  parameter int RAM_BLOCKS  = 8,
  parameter int NAC_CYCLES  = 2,
  parameter int BUSY_CYCLES = 16
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [3:0]                    idata_sd,
  output logic [3:0]                    odata_sd,
  output logic                          odata_sd_en,
  input  logic                          isend,
  input  logic                          irecv,
  output logic [$clog2(RAM_BLOCKS)-1:0] osel_ram,
  output logic [9:0]                    oaddr,
  input  logic [3:0]                    irdata,
  output logic [3:0]                    owdata,
  output logic                          owrite_en,
  output logic                          ocrc_err,
  output logic                          odone,
  output logic                          obusy
);

  localparam int SEL_W = $clog2(RAM_BLOCKS);
  localparam int CNT_W = 16;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(RAM_BLOCKS - 1);

  // Control handshake: isend/irecv are single-cycle requests sampled only in
  // IDLE (isend has priority); obusy is high from the following clock until
  // the transaction ends, and odone pulses for one clock when it does.

  typedef enum logic [3:0] {
    IDLE,
    SEND_WAIT,
    SEND_START,
    SEND_DATA,
    SEND_CRC,
    SEND_END,
    RCV_WAIT,
    RCV_DATA,
    RCV_CRC,
    RCV_END,
    RCV_TURN,
    RCV_STATUS,
    RCV_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][15:0]  crc_q, crc_d;
  logic              err_q, err_d;
  logic [3:0]        data_d;
  logic              en_d;
  logic [9:0]        addr_d;
  logic [SEL_W-1:0]  sel_d;
  logic              crc_err_d;
  logic              done_d;
  logic [4:0]        tok;
  logic [3:0]        crc_msb;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // D0 status token, MSB first: start 0, three status bits, end 1.
  assign tok     = err_q ? 5'b01011 : 5'b00101;
  assign crc_msb = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};

  assign owdata    = idata_sd;
  assign owrite_en = (state_q == RCV_DATA);
  assign obusy     = (state_q != IDLE);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      err_q       <= 1'b0;
      odata_sd    <= 4'hF;
      odata_sd_en <= 1'b0;
      oaddr       <= '0;
      osel_ram    <= '0;
      ocrc_err    <= 1'b0;
      odone       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      odata_sd    <= data_d;
      odata_sd_en <= en_d;
      oaddr       <= addr_d;
      osel_ram    <= sel_d;
      ocrc_err    <= crc_err_d;
      odone       <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    err_d     = err_q;
    data_d    = odata_sd;
    en_d      = odata_sd_en;
    addr_d    = oaddr;
    sel_d     = osel_ram;
    crc_err_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        data_d = 4'hF;
        en_d   = 1'b0;
        addr_d = '0;
        sel_d  = '0;
        cnt_d  = '0;
        if (isend) begin
          state_d = SEND_WAIT;
        end else if (irecv) begin
          state_d = RCV_WAIT;
        end
      end

      SEND_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NAC_CYCLES - 1)) begin
          state_d = SEND_START;
          data_d  = 4'h0;
          en_d    = 1'b1;
          addr_d  = '0;
          crc_d   = '0;
        end
      end

      // The output register lags oaddr by one clock, so the RAM word for
      // address n is captured on the edge that advances oaddr to n+1.
      SEND_START: begin
        state_d = SEND_DATA;
        data_d  = irdata;
        addr_d  = oaddr + 10'd1;
        for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], irdata[i]);
      end

      SEND_DATA: begin
        if (oaddr == 10'd0) begin
          state_d = SEND_CRC;
          cnt_d   = '0;
          data_d  = crc_msb;
          for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
        end else begin
          data_d = irdata;
          addr_d = oaddr + 10'd1;
          for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], irdata[i]);
        end
      end

      SEND_CRC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(15)) begin
          state_d = SEND_END;
          data_d  = 4'hF;
        end else begin
          data_d = crc_msb;
          for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
        end
      end

      SEND_END: begin
        en_d   = 1'b0;
        data_d = 4'hF;
        cnt_d  = '0;
        if (osel_ram == LAST_SEL) begin
          state_d = IDLE;
          sel_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = SEND_WAIT;
          sel_d   = osel_ram + SEL_W'(1);
        end
      end

      RCV_WAIT: begin
        en_d   = 1'b0;
        data_d = 4'hF;
        if (idata_sd == 4'h0) begin
          state_d = RCV_DATA;
          addr_d  = '0;
          crc_d   = '0;
          err_d   = 1'b0;
        end
      end

      RCV_DATA: begin
        addr_d = oaddr + 10'd1;
        for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], idata_sd[i]);
        if (oaddr == 10'd1023) begin
          state_d = RCV_CRC;
          cnt_d   = '0;
        end
      end

      RCV_CRC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (idata_sd != crc_msb) err_d = 1'b1;
        for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
        if (cnt_q == CNT_W'(15)) state_d = RCV_END;
      end

      RCV_END: begin
        if (idata_sd != 4'hF) err_d = 1'b1;
        state_d = RCV_TURN;
        cnt_d   = '0;
      end

      RCV_TURN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RCV_STATUS;
          cnt_d   = '0;
          en_d    = 1'b1;
          data_d  = 4'b1110;
        end
      end

      RCV_STATUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(4)) begin
          cnt_d = '0;
          if (err_q) begin
            state_d   = IDLE;
            en_d      = 1'b0;
            data_d    = 4'hF;
            sel_d     = '0;
            crc_err_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d = RCV_BUSY;
            data_d  = 4'b1110;
          end
        end else begin
          data_d = {3'b111, tok[2'd3 - cnt_q[1:0]]};
        end
      end

      // D0 low for BUSY_CYCLES clocks, then one clock high before release.
      RCV_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BUSY_CYCLES - 1)) begin
          data_d = 4'hF;
        end else if (cnt_q == CNT_W'(BUSY_CYCLES)) begin
          en_d   = 1'b0;
          data_d = 4'hF;
          cnt_d  = '0;
          if (osel_ram == LAST_SEL) begin
            state_d = IDLE;
            sel_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = RCV_WAIT;
            sel_d   = osel_ram + SEL_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
